irq_controller: RTL and testbench

- Interrupt controller that drives the CPU's 16-bit `interrupts` input, which is currently tied to zero at top level.
- Collects up to 16 device request lines: PS/2 ready, UART rx, VGA vsync, timers and software requests.
- Latches each request into a pending register, masks it with a software-programmable enable register, and presents the pending-and-enabled vector plus the highest-priority ID to the CPU.
- Its registers are exposed as a 4-word MMIO block, decoded by mem.

---
 rtl/irq_controller.sv | 130 +++++++++++++
 tb/tb_irq_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Interrupt controller: latches up to 16 request lines into PENDING, gates them with MASK,
// and presents the enabled vector plus the lowest-index (highest-priority) ID to the CPU.
module irq_controller #(
  parameter int unsigned NUM_SRC    = 16,
  parameter logic [15:0] EDGE_MASK  = 16'hFFFF,
  parameter logic [15:0] MASK_RESET = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] src_i,
  input  logic [3:0]  reg_wen_i,
  input  logic [1:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        reg_ren_i,
  input  logic [1:0]  reg_raddr_i,
  output logic [31:0] reg_rdata_o,
  input  logic        ack_i,
  input  logic [3:0]  ack_id_i,
  output logic [15:0] interrupts_o,
  output logic        irq_valid_o,
  output logic [3:0]  irq_id_o
);

  localparam logic [1:0] AddrPending = 2'd0;
  localparam logic [1:0] AddrMask    = 2'd1;
  localparam logic [1:0] AddrSwset   = 2'd2;
  localparam logic [1:0] AddrStatus  = 2'd3;

  // Bits at or above NUM_SRC are forced to zero in every register.
  localparam logic [16:0] ImplMaskW = (17'd1 << NUM_SRC) - 17'd1;
  localparam logic [15:0] ImplMask  = ImplMaskW[15:0];

  logic [15:0] pending_q, pending_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] src_prev_q;
  logic [31:0] rdata_q, rdata_d;

  logic [15:0] lane_en;
  logic [15:0] wbits;
  logic [15:0] hw_set;
  logic [15:0] sw_set;
  logic [15:0] w1c_clr;
  logic [15:0] ack_clr;
  logic [15:0] irq_vec;
  logic [3:0]  irq_id;

  // Upper byte lanes and upper write data carry nothing in this block.
  logic unused_upper;
  assign unused_upper = ^{reg_wdata_i[31:16], reg_wen_i[3:2]};

  assign lane_en = {{8{reg_wen_i[1]}}, {8{reg_wen_i[0]}}};
  assign wbits   = reg_wdata_i[15:0] & lane_en & ImplMask;

  always_comb begin
    hw_set = ((src_i & ~src_prev_q & EDGE_MASK) | (src_i & ~EDGE_MASK)) & ImplMask;
  end

  always_comb begin
    sw_set  = '0;
    w1c_clr = '0;
    unique case (reg_waddr_i)
      AddrPending: w1c_clr = wbits;
      AddrSwset:   sw_set  = wbits;
      default: ;
    endcase
  end

  always_comb begin
    ack_clr = '0;
    if (ack_i && (32'(ack_id_i) < NUM_SRC)) begin
      ack_clr[ack_id_i] = 1'b1;
    end
  end

  // Sets dominate clears so a request arriving alongside an ack or W1C is never dropped.
  always_comb begin
    pending_d = ((pending_q & ~(w1c_clr | ack_clr)) | hw_set | sw_set) & ImplMask;
  end

  always_comb begin
    mask_d = mask_q;
    if (reg_waddr_i == AddrMask) begin
      mask_d = ((mask_q & ~lane_en) | (reg_wdata_i[15:0] & lane_en)) & ImplMask;
    end
  end

  assign irq_vec = pending_q & mask_q;

  always_comb begin
    irq_id = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (irq_vec[i]) begin
        irq_id = i[3:0];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (reg_ren_i) begin
      unique case (reg_raddr_i)
        AddrPending: rdata_d = {16'h0000, pending_q};
        AddrMask:    rdata_d = {16'h0000, mask_q};
        AddrSwset:   rdata_d = 32'h0000_0000;
        AddrStatus:  rdata_d = {15'd0, |irq_vec, 12'd0, irq_id};
        default:     rdata_d = 32'h0000_0000;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      mask_q     <= MASK_RESET & ImplMask;
      src_prev_q <= '0;
      rdata_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      src_prev_q <= src_i & ImplMask;
      rdata_q    <= rdata_d;
    end
  end

  assign interrupts_o = irq_vec;
  assign irq_valid_o  = |irq_vec;
  assign irq_id_o     = irq_id;
  assign reg_rdata_o  = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic against a behavioural
// model; instance a uses defaults, instance b has 12 sources, src[1] level-triggered.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] src;
  logic [3:0]  wen;
  logic [1:0]  waddr;
  logic [31:0] wdata;
  logic        ren;
  logic [1:0]  raddr;
  logic        ack;
  logic [3:0]  ack_id;

  logic [31:0] o_rdata[2];
  logic [15:0] o_int[2];
  logic        o_val[2];
  logic [3:0]  o_id[2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_controller u_dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .src_i        (src),
    .reg_wen_i    (wen),
    .reg_waddr_i  (waddr),
    .reg_wdata_i  (wdata),
    .reg_ren_i    (ren),
    .reg_raddr_i  (raddr),
    .reg_rdata_o  (o_rdata[0]),
    .ack_i        (ack),
    .ack_id_i     (ack_id),
    .interrupts_o (o_int[0]),
    .irq_valid_o  (o_val[0]),
    .irq_id_o     (o_id[0])
  );

  irq_controller #(
    .NUM_SRC    (12),
    .EDGE_MASK  (16'hFFFD),
    .MASK_RESET (16'h0A5F)
  ) u_dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .src_i        (src),
    .reg_wen_i    (wen),
    .reg_waddr_i  (waddr),
    .reg_wdata_i  (wdata),
    .reg_ren_i    (ren),
    .reg_raddr_i  (raddr),
    .reg_rdata_o  (o_rdata[1]),
    .ack_i        (ack),
    .ack_id_i     (ack_id),
    .interrupts_o (o_int[1]),
    .irq_valid_o  (o_val[1]),
    .irq_id_o     (o_id[1])
  );

  // Reference model state and per-instance configuration.
  int unsigned p_num[2]  = '{16, 12};
  logic [15:0] p_edge[2] = '{16'hFFFF, 16'hFFFD};
  logic [15:0] p_mrst[2] = '{16'h0000, 16'h0A5F};
  logic [15:0] m_pend[2];
  logic [15:0] m_mask[2];
  logic [15:0] m_prev[2];
  logic [31:0] m_rdata[2];

  function automatic logic [15:0] m_int(int k);
    return m_pend[k] & m_mask[k];
  endfunction

  function automatic logic [3:0] m_id(int k);
    logic [15:0] v = m_int(k);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k]  = 16'h0;
      m_mask[k]  = p_mrst[k];
      m_prev[k]  = 16'h0;
      m_rdata[k] = 32'h0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] np = m_pend[k];
      logic [15:0] nm = m_mask[k];
      if (ren) begin
        case (raddr)
          2'd0: m_rdata[k] = {16'h0, m_pend[k]};
          2'd1: m_rdata[k] = {16'h0, m_mask[k]};
          2'd2: m_rdata[k] = 32'h0;
          default: m_rdata[k] = (m_int(k) != 0 ? 32'h0001_0000 : 32'h0) | 32'(m_id(k));
        endcase
      end
      for (int i = 0; i < int'(p_num[k]); i++) begin
        logic lane = (i < 8) ? wen[0] : wen[1];
        logic wbit = lane && wdata[i];
        logic set  = p_edge[k][i] ? (src[i] && !m_prev[k][i]) : src[i];
        logic clr  = (waddr == 2'd0 && wbit) || (ack && int'(ack_id) == i);
        if (waddr == 2'd2 && wbit) set = 1'b1;
        if (set) np[i] = 1'b1;
        else if (clr) np[i] = 1'b0;
        if (waddr == 2'd1 && lane) nm[i] = wdata[i];
        m_prev[k][i] = src[i];
      end
      m_pend[k] = np;
      m_mask[k] = nm;
    end
  endtask

  task automatic cycle();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 4'b0000; ren = 1'b0; ack = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] lanes);
    waddr = a; wdata = d; wen = lanes;
    cycle();
    idle();
  endtask

  task automatic rd(input logic [1:0] a);
    raddr = a; ren = 1'b1;
    cycle();
    idle();
  endtask

  task automatic do_ack(input logic [3:0] id);
    ack = 1'b1; ack_id = id;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src = '0; waddr = '0; wdata = '0; raddr = '0; ack_id = '0;
    idle();
    model_reset();
    #12;
    total++; if (o_int[0] !== 16'h0) begin bad++; $display("FAIL reset_int got=%h exp=0000", o_int[0]); end
    total++; if (o_val[0] !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_val[0]); end
    total++; if (o_id[0] !== 4'd0) begin bad++; $display("FAIL reset_id got=%h exp=0", o_id[0]); end
    total++; if (o_rdata[0] !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", o_rdata[0]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(2'd1);
    total++; if (o_rdata[1] !== 32'h0000_0A5F) begin
      bad++; $display("FAIL reset_mask_b got=%h exp=00000a5f", o_rdata[1]);
    end
  endtask

  task automatic test_masked_pend();
    src = 16'h0008; cycle(); src = 16'h0;
    rd(2'd0);
    total++; if (o_rdata[0] !== 32'h0000_0008) begin bad++; $display("FAIL masked_pend_read got=%h exp=00000008", o_rdata[0]); end
    total++; if (o_int[0] !== 16'h0) begin bad++; $display("FAIL masked_int got=%h exp=0000", o_int[0]); end
    total++; if (o_val[0] !== 1'b0) begin bad++; $display("FAIL masked_valid got=%b exp=0", o_val[0]); end
    wr(2'd1, 32'h0000_0008, 4'b0011);
    total++; if (o_int[0] !== 16'h0008) begin bad++; $display("FAIL unmask_int got=%h exp=0008", o_int[0]); end
    total++; if (o_val[0] !== 1'b1) begin bad++; $display("FAIL unmask_valid got=%b exp=1", o_val[0]); end
    total++; if (o_id[0] !== 4'd3) begin bad++; $display("FAIL unmask_id got=%0d exp=3", o_id[0]); end
  endtask

  task automatic test_priority();
    wr(2'd1, 32'h0000_FFFF, 4'b0011);
    wr(2'd0, 32'h0000_FFFF, 4'b0011);
    src = 16'h0024; cycle(); src = 16'h0;
    total++; if (o_id[0] !== 4'd2) begin bad++; $display("FAIL prio_id got=%0d exp=2", o_id[0]); end
    do_ack(4'd2);
    total++; if (o_id[0] !== 4'd5) begin bad++; $display("FAIL prio_ack_id got=%0d exp=5", o_id[0]); end
    total++; if (o_int[0] !== 16'h0020) begin bad++; $display("FAIL prio_ack_int got=%h exp=0020", o_int[0]); end
    do_ack(4'd9);
    total++; if (o_int[0] !== 16'h0020) begin bad++; $display("FAIL ack_nonpending got=%h exp=0020", o_int[0]); end
    wr(2'd0, 32'h0000_FFFF, 4'b0011);
  endtask

  task automatic test_edge_level();
    wr(2'd1, 32'h0000_FFFF, 4'b0011);  // also opens all of b's implemented sources
    src = 16'h0002;
    for (int n = 0; n < 10; n++) cycle();
    total++; if (o_int[0] !== 16'h0002) begin bad++; $display("FAIL edge_hold got=%h exp=0002", o_int[0]); end
    do_ack(4'd1);
    cycle(); cycle();
    total++; if (o_int[0] !== 16'h0000) begin bad++; $display("FAIL edge_after_ack got=%h exp=0000", o_int[0]); end
    total++; if (o_int[1] !== 16'h0002) begin bad++; $display("FAIL level_repend got=%h exp=0002", o_int[1]); end
    src = 16'h0;
    cycle();
    wr(2'd0, 32'h0000_FFFF, 4'b0011);
  endtask

  task automatic test_set_vs_w1c();
    src = 16'h0010; waddr = 2'd0; wdata = 32'h0000_0010; wen = 4'b0011;
    cycle();
    idle(); src = 16'h0;
    total++; if (o_int[0] !== 16'h0010) begin bad++; $display("FAIL set_beats_w1c got=%h exp=0010", o_int[0]); end
    wr(2'd0, 32'h0000_0010, 4'b0001);
    total++; if (o_int[0] !== 16'h0000) begin bad++; $display("FAIL w1c_clear got=%h exp=0000", o_int[0]); end
  endtask

  task automatic test_swset_lanes();
    wr(2'd2, 32'h0000_8000, 4'b0010);
    rd(2'd0);
    total++; if (o_rdata[0] !== 32'h0000_8000) begin bad++; $display("FAIL swset_lane1 got=%h exp=00008000", o_rdata[0]); end
    rd(2'd3);
    total++; if (o_rdata[0] !== 32'h0001_000F) begin bad++; $display("FAIL status_read got=%h exp=0001000f", o_rdata[0]); end
    rd(2'd2);
    total++; if (o_rdata[0] !== 32'h0) begin bad++; $display("FAIL swset_reads_zero got=%h exp=0", o_rdata[0]); end
    wr(2'd0, 32'h0000_FFFF, 4'b0011);
    wr(2'd2, 32'h0000_8000, 4'b0100);
    rd(2'd0);
    total++; if (o_rdata[0] !== 32'h0) begin bad++; $display("FAIL swset_lane2 got=%h exp=0", o_rdata[0]); end
  endtask

  task automatic test_async_reset();
    wr(2'd2, 32'h0000_00FF, 4'b0001);
    rd(2'd0);
    total++; if (o_rdata[0] !== 32'h0000_00FF) begin bad++; $display("FAIL pre_reset_pend got=%h exp=000000ff", o_rdata[0]); end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (o_int[0] !== 16'h0) begin bad++; $display("FAIL async_int got=%h exp=0000", o_int[0]); end
    total++; if (o_rdata[0] !== 32'h0) begin bad++; $display("FAIL async_rdata got=%h exp=0", o_rdata[0]); end
    src = 16'h0002;
    @(posedge clk); #1;
    cycle();
    rst_n = 1'b1;
    cycle();
    total++; if (o_int[1] !== 16'h0002) begin bad++; $display("FAIL level_after_reset got=%h exp=0002", o_int[1]); end
    src = 16'h0;
    rd(2'd1);
    total++; if (o_rdata[0] !== 32'h0) begin bad++; $display("FAIL mask_after_reset got=%h exp=0", o_rdata[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      src    = 16'($urandom) & 16'($urandom) & 16'($urandom);
      wen    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      waddr  = 2'($urandom);
      wdata  = $urandom & $urandom;
      ren    = 1'($urandom);
      raddr  = 2'($urandom);
      ack    = ($urandom_range(0, 2) == 0);
      ack_id = 4'($urandom);
      cycle();
      for (int k = 0; k < 2; k++) begin
        total++; if (o_int[k] !== m_int(k)) begin
          bad++; $display("FAIL rand_int[%0d] cyc=%0d got=%h exp=%h", k, n, o_int[k], m_int(k));
        end
        total++; if (o_val[k] !== (m_int(k) != 16'h0)) begin
          bad++; $display("FAIL rand_valid[%0d] cyc=%0d got=%b exp=%b", k, n, o_val[k], m_int(k) != 16'h0);
        end
        total++; if (o_id[k] !== m_id(k)) begin
          bad++; $display("FAIL rand_id[%0d] cyc=%0d got=%0d exp=%0d", k, n, o_id[k], m_id(k));
        end
        total++; if (o_rdata[k] !== m_rdata[k]) begin
          bad++; $display("FAIL rand_rdata[%0d] cyc=%0d got=%h exp=%h", k, n, o_rdata[k], m_rdata[k]);
        end
      end
    end
    idle();
    src = 16'h0;
  endtask

  initial begin
    test_reset();
    test_masked_pend();
    test_priority();
    test_edge_level();
    test_set_vs_w1c();
    test_swset_lanes();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
